poly_decompress_sched: RTL and testbench

Two-requester round-robin scheduler that shares one `poly_decompress` engine inside the Kyber512 CCA2 decapsulation core. Typical requesters are the decryption path (ciphertext `v` decompression) and the re-encryption/compare path. The block does the following:
- arbitrates between the requesters;
- latches the granted compressed polynomial;
- issues a single start to the engine;
- waits for the engine's completion pulse;
- returns the 256-coefficient result to the winner.

---
 rtl/kyber_pkg.sv | 16 +
 rtl/poly_decompress_sched_if.sv | 17 +
 rtl/poly_decompress_sched_rr_arb2.sv | 19 +
 rtl/poly_decompress_sched.sv | 142 ++++++++++++++
 tb/tb_poly_decompress_sched.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber512 constants, bus widths and the decompress scheduler state type.
package kyber_pkg;

   localparam int KYBER_N                   = 256;
   localparam int KYBER_POLYCOMPRESSEDBYTES = 96;
   localparam int KYBER_DATA_W              = 12;
   localparam int KYBER_CW                  = 8 * KYBER_POLYCOMPRESSEDBYTES;
   localparam int KYBER_PW                  = KYBER_DATA_W * KYBER_N;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } sched_state_t;

endpackage

// File: rtl/poly_decompress_sched_if.sv
// Channel between the scheduler and the shared poly_decompress engine.
interface poly_decompress_sched_if
   import kyber_pkg::*;
#(
   parameter int CW = KYBER_CW,
   parameter int PW = KYBER_PW
);

   logic          eng_enable;
   logic [CW-1:0] eng_cpoly;
   logic          eng_out_ready;
   logic [PW-1:0] eng_poly;

   modport master (output eng_enable, eng_cpoly, input eng_out_ready, eng_poly);
   modport slave  (input eng_enable, eng_cpoly, output eng_out_ready, eng_poly);

endinterface

// File: rtl/poly_decompress_sched_rr_arb2.sv
// Combinational two-way round-robin pick; a tie goes to the side not served last.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt_vec,
   output logic       winner
);

   // tie -> the other one than last; single request -> that one
   always_comb begin
      winner = 1'b0;
      if (req == 2'b11)
         winner = ~last;
      else if (req[1])
         winner = 1'b1;
      gnt_vec = {winner, ~winner} & {2{|req}};
   end

endmodule

// File: rtl/poly_decompress_sched.sv
// Two-requester round-robin front end for one poly_decompress engine.
// Optional engine watchdog: define DECOMP_TIMEOUT_EN.
module poly_decompress_sched #(
   parameter int KYBER_POLYCOMPRESSEDBYTES = kyber_pkg::KYBER_POLYCOMPRESSEDBYTES,
   parameter int KYBER_N                   = kyber_pkg::KYBER_N,
   parameter int data_Width                = kyber_pkg::KYBER_DATA_W,
   parameter int TIMEOUT                   = 64,
   parameter int CW                        = 8 * KYBER_POLYCOMPRESSEDBYTES,
   parameter int PW                        = data_Width * KYBER_N
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            req0,
   input  logic                            req1,
   input  logic [CW-1:0]                   cpoly0,
   input  logic [CW-1:0]                   cpoly1,
   output logic                            gnt0,
   output logic                            gnt1,
   output logic                            done0,
   output logic                            done1,
   output logic [PW-1:0]                   poly_out,
   output logic                            err,
   output logic                            busy,
   poly_decompress_sched_if.master         eng
);
   import kyber_pkg::*;

   // a zero watchdog limit would make the counter compare meaningless
   if (TIMEOUT < 1) begin : g_bad_cfg
      $error("TIMEOUT must be at least 1");
   end

   sched_state_t state, state_nxt;
   logic         last, owner;
   logic [1:0]   req, gnt_vec;
   logic         winner;
   logic         fire_done;

   assign req = {req1, req0};

   rr_arb2 u_arb (
      .req     (req),
      .last    (last),
      .gnt_vec (gnt_vec),
      .winner  (winner)
   );

`ifdef DECOMP_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            fire_err;

   // watchdog: cleared while issuing, counts every WAIT cycle
   always_ff @(posedge clk) begin
      if (reset)
         wd_cnt <= '0;
      else if (state == ISSUE)
         wd_cnt <= '0;
      else if (state == WAIT)
         wd_cnt <= wd_cnt + 1'b1;
   end

   // error pulse rides along with the timeout done
   always_ff @(posedge clk) begin
      if (reset)
         err <= 1'b0;
      else
         err <= fire_err;
   end
`else
   assign err = 1'b0;
`endif

   // next state; completion takes priority over watchdog expiry
   always_comb begin
      state_nxt = state;
      fire_done = 1'b0;
`ifdef DECOMP_TIMEOUT_EN
      fire_err  = 1'b0;
`endif
      case (state)
         IDLE:  if (|req) state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (eng.eng_out_ready) begin
               fire_done = 1'b1;
               state_nxt = IDLE;
            end
`ifdef DECOMP_TIMEOUT_EN
            else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
               fire_done = 1'b1;
               fire_err  = 1'b1;
               state_nxt = IDLE;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state, arbitration pointer and registered control pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         last           <= 1'b1;
         owner          <= 1'b0;
         gnt0           <= 1'b0;
         gnt1           <= 1'b0;
         done0          <= 1'b0;
         done1          <= 1'b0;
         busy           <= 1'b0;
         eng.eng_enable <= 1'b0;
      end else begin
         state          <= state_nxt;
         gnt0           <= (state == IDLE) & gnt_vec[0];
         gnt1           <= (state == IDLE) & gnt_vec[1];
         eng.eng_enable <= (state == ISSUE);
         done0          <= fire_done & ~owner;
         done1          <= fire_done & owner;
         // busy covers the grant cycle through the done cycle
         busy           <= (state_nxt != IDLE) | fire_done;
         if (state == IDLE && |req) begin
            owner <= winner;
            last  <= winner;
         end
      end
   end

   // capture the winner's compressed poly and the engine's result
   always_ff @(posedge clk) begin
      if (reset) begin
         eng.eng_cpoly <= '0;
         poly_out      <= '0;
      end else begin
         if (state == IDLE && |req)
            eng.eng_cpoly <= winner ? cpoly1 : cpoly0;
         if (state == WAIT && eng.eng_out_ready)
            poly_out <= eng.eng_poly;
      end
   end

endmodule

// File: tb/tb_poly_decompress_sched.sv
// Randomized bench for poly_decompress_sched with a transaction-level model.
module tb_poly_decompress_sched;
   import kyber_pkg::*;

   localparam int CW = KYBER_CW;
   localparam int PW = KYBER_PW;
   localparam int TO = 8;
`ifdef DECOMP_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, req1;
   logic [CW-1:0] cpoly0, cpoly1;
   logic          gnt0, gnt1, done0, done1, err, busy;
   logic [PW-1:0] poly_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   poly_decompress_sched_if #(.CW(CW), .PW(PW)) eng ();

   poly_decompress_sched #(.TIMEOUT(TO)) dut (
      .clk      (clk),
      .reset    (reset),
      .req0     (req0),
      .req1     (req1),
      .cpoly0   (cpoly0),
      .cpoly1   (cpoly1),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .done0    (done0),
      .done1    (done1),
      .poly_out (poly_out),
      .err      (err),
      .busy     (busy),
      .eng      (eng)
   );

   task automatic check(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] rnd_cw();
      logic [CW-1:0] r;
      for (int i = 0; i < CW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [PW-1:0] rnd_pw();
      logic [PW-1:0] r;
      for (int i = 0; i < PW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // ---------------- behavioural model ----------------
   // A transaction is "active" from its grant edge; edges since grant decide
   // when the start pulse is due and when engine responses count.
   logic [1:0]    e_gnt, e_done;
   logic          e_err, e_busy, e_en;
   logic [CW-1:0] e_cpoly;
   logic [PW-1:0] e_poly;
   bit            started = 1'b0;
   bit            m_act, m_last, m_own;
   int            m_age;

   initial forever begin
      @(posedge clk);
      started = 1'b1;
      e_gnt = 2'b00; e_done = 2'b00; e_err = 1'b0; e_en = 1'b0;
      if (reset) begin
         m_act = 1'b0; m_last = 1'b1; m_own = 1'b0;
         e_busy = 1'b0; e_cpoly = '0; e_poly = '0;
      end else if (!m_act) begin
         if (req0 | req1) begin
            m_own  = (req0 & req1) ? ~m_last : req1;
            m_last = m_own;
            m_act  = 1'b1;
            m_age  = 0;
            e_gnt[m_own] = 1'b1;
            e_cpoly = m_own ? cpoly1 : cpoly0;
            e_busy = 1'b1;
         end else begin
            e_busy = 1'b0;
         end
      end else begin
         m_age++;
         e_busy = 1'b1;
         if (m_age == 1) begin
            e_en = 1'b1;
         end else if (eng.eng_out_ready) begin
            e_done[m_own] = 1'b1;
            e_poly = eng.eng_poly;
            m_act = 1'b0;
         end else if (TO_EN && (m_age - 1) == TO) begin
            e_done[m_own] = 1'b1;
            e_err = 1'b1;
            m_act = 1'b0;
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   initial forever begin
      @(negedge clk);
      if (started) begin
         check("gnt",   {gnt1, gnt0} === e_gnt,   64'({gnt1, gnt0}),   64'(e_gnt));
         check("done",  {done1, done0} === e_done, 64'({done1, done0}), 64'(e_done));
         check("err",   err === e_err,   64'(err),   64'(e_err));
         check("busy",  busy === e_busy, 64'(busy),  64'(e_busy));
         check("eng_enable", eng.eng_enable === e_en, 64'(eng.eng_enable), 64'(e_en));
         check("eng_cpoly", eng.eng_cpoly === e_cpoly, eng.eng_cpoly[63:0], e_cpoly[63:0]);
         check("poly_out", poly_out === e_poly, poly_out[63:0], e_poly[63:0]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(output logic who);
      int n = 0;
      do begin cyc(); n++; end while (!(gnt0 | gnt1) && n < 20);
      check("gnt_seen", (gnt0 ^ gnt1) === 1'b1, 64'({gnt1, gnt0}), 64'd1);
      who = gnt1;
   endtask

   // grant, start, engine answers two cycles later; returns the done vector
   task automatic run_txn(input bit drop, output logic who, output logic [1:0] dn);
      wait_gnt(who);
      if (drop) begin
         if (who) req1 = 1'b0; else req0 = 1'b0;
      end else begin
         if (who) cpoly1 = rnd_cw(); else cpoly0 = rnd_cw();
      end
      cyc();
      cyc();
      eng.eng_out_ready = 1'b1;
      eng.eng_poly = rnd_pw();
      cyc();
      eng.eng_out_ready = 1'b0;
      dn = {done1, done0};
   endtask

   initial begin
      logic          who;
      logic [1:0]    dn;
      logic [PW-1:0] pfix;
      logic [CW-1:0] c_fa;
      int            eng_cd;
      int            n;

      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; cpoly0 = '0; cpoly1 = '0;
      eng.eng_out_ready = 1'b0; eng.eng_poly = '0;
      eng_cd = 0; n = 0;
      cyc(); cyc();
      check("rst_ctrl", {gnt1, gnt0, done1, done0, err, busy, eng.eng_enable} === 7'b0,
            64'({gnt1, gnt0, done1, done0, err, busy, eng.eng_enable}), 64'd0);
      check("rst_data", (poly_out === '0) && (eng.eng_cpoly === '0), poly_out[63:0], 64'd0);

      // lone request
      c_fa = '0; c_fa[11:0] = 12'h0FA;
      reset = 1'b0; req0 = 1'b1; cpoly0 = c_fa;
      cyc();
      check("lone_gnt", {gnt1, gnt0} === 2'b01, 64'({gnt1, gnt0}), 64'd1);
      check("lone_cpoly", eng.eng_cpoly === c_fa, eng.eng_cpoly[63:0], 64'h0FA);
      req0 = 1'b0;
      cyc();
      check("lone_en", eng.eng_enable === 1'b1, 64'(eng.eng_enable), 64'd1);
      cyc(); cyc();
      pfix = {(PW / 32){32'hA5C3_0F12}};
      eng.eng_poly = pfix; eng.eng_out_ready = 1'b1;
      cyc();
      eng.eng_out_ready = 1'b0;
      check("lone_done", {err, done1, done0} === 3'b001, 64'({err, done1, done0}), 64'd1);
      check("lone_poly", poly_out === pfix, poly_out[63:0], pfix[63:0]);

      // spurious engine pulse while idle
      eng.eng_poly = ~pfix; eng.eng_out_ready = 1'b1;
      cyc();
      eng.eng_out_ready = 1'b0;
      check("spur_nodone", {done1, done0} === 2'b00, 64'({done1, done0}), 64'd0);
      check("spur_poly", poly_out === pfix, poly_out[63:0], pfix[63:0]);

      // tie from reset, both held: 0,1,0,1
      reset = 1'b1; cyc(); reset = 1'b0;
      req0 = 1'b1; req1 = 1'b1; cpoly0 = rnd_cw(); cpoly1 = rnd_cw();
      for (int k = 0; k < 4; k++) begin
         run_txn(1'b0, who, dn);
         check("tie_order", who === k[0], 64'(who), 64'(k[0]));
         check("tie_done", dn === (k[0] ? 2'b10 : 2'b01), 64'(dn), 64'(k[0] ? 2 : 1));
      end

      // req1 withdrawn after its grant still completes
      req0 = 1'b0;
      run_txn(1'b1, who, dn);
      check("wd_who", who === 1'b1, 64'(who), 64'd1);
      check("wd_done", dn === 2'b10, 64'(dn), 64'd2);

`ifdef DECOMP_TIMEOUT_EN
      // silent engine: done+err after exactly TO WAIT cycles
      req0 = 1'b1; wait_gnt(who); req0 = 1'b0;
      cyc();
      n = 0;
      do begin cyc(); n++; end while (!(done0 | done1) && n < 20);
      check("to_cycles", n == TO, 64'(n), 64'(TO));
      check("to_err", {err, done1, done0} === 3'b101, 64'({err, done1, done0}), 64'd5);
      // response in the last WAIT cycle wins over expiry
      req0 = 1'b1; wait_gnt(who); req0 = 1'b0;
      cyc();
      repeat (TO - 1) cyc();
      pfix = rnd_pw();
      eng.eng_poly = pfix; eng.eng_out_ready = 1'b1;
      cyc();
      eng.eng_out_ready = 1'b0;
      check("to_late_done", {err, done1, done0} === 3'b001, 64'({err, done1, done0}), 64'd1);
      check("to_late_poly", poly_out === pfix, poly_out[63:0], pfix[63:0]);
`endif

      // reset in WAIT discards the transaction and restores the tie pointer
      req0 = 1'b1; req1 = 1'b1; wait_gnt(who);
      cyc();
      reset = 1'b1;
      cyc();
      check("rstw_ctrl", {gnt1, gnt0, done1, done0, err, busy, eng.eng_enable} === 7'b0,
            64'({gnt1, gnt0, done1, done0, err, busy, eng.eng_enable}), 64'd0);
      check("rstw_data", (poly_out === '0) && (eng.eng_cpoly === '0), poly_out[63:0], 64'd0);
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
      eng.eng_out_ready = 1'b1; eng.eng_poly = rnd_pw();
      cyc();
      eng.eng_out_ready = 1'b0;
      check("rstw_ignored", {done1, done0, busy} === 3'b000, 64'({done1, done0, busy}), 64'd0);
      check("rstw_poly", poly_out === '0, poly_out[63:0], 64'd0);
      req0 = 1'b1; req1 = 1'b1; cpoly0 = rnd_cw(); cpoly1 = rnd_cw();
      wait_gnt(who);
      check("rstw_tie", who === 1'b0, 64'(who), 64'd0);

      // random traffic with a latency-randomized engine
      for (int c = 0; c < 3000; c++) begin
         eng.eng_out_ready = 1'b0;
         if (eng.eng_enable) eng_cd = $urandom_range(2, TO_EN ? 12 : 6);
         if (eng_cd > 0) begin
            eng_cd--;
            if (eng_cd == 0) begin
               eng.eng_out_ready = 1'b1; eng.eng_poly = rnd_pw();
            end
         end else if ($urandom_range(0, 24) == 0) begin
            eng.eng_out_ready = 1'b1; eng.eng_poly = rnd_pw();
         end
         reset = ($urandom_range(0, 499) == 0);
         if (reset) eng_cd = 0;
         if (gnt0) begin
            req0 = 1'($urandom_range(0, 1)); cpoly0 = rnd_cw();
         end else if (req0) begin
            if ($urandom_range(0, 39) == 0) req0 = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            req0 = 1'b1; cpoly0 = rnd_cw();
         end
         if (gnt1) begin
            req1 = 1'($urandom_range(0, 1)); cpoly1 = rnd_cw();
         end else if (req1) begin
            if ($urandom_range(0, 39) == 0) req1 = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            req1 = 1'b1; cpoly1 = rnd_cw();
         end
         cyc();
      end

      reset = 1'b0; req0 = 1'b0; req1 = 1'b0; eng.eng_out_ready = 1'b0;
      cyc(); cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard stop if the run ever stalls
   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got stalled want finished");
      $fatal(1, "simulation time limit");
   end

endmodule
